// File: rtl/fpa_add_unit_pkg.sv
// Shared constants, FSM encoding and unpacked-operand layout for the
// multi-cycle single-precision adder.
package fpa_pkg;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int WORD_W   = 1 + EXP_W + MAN_W;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  // hidden bit + stored mantissa + guard/round/sticky
  localparam int MX_W     = MAN_W + 4;
  localparam int LZ_W     = $clog2(MX_W + 1);
  localparam logic [WORD_W-1:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man;  // hidden bit in the MSB
  } unpacked_t;

  // Denormals flush to a signed zero (exp = 0, man = 0).
  function automatic unpacked_t unpack(input logic [WORD_W-1:0] w, input logic flip);
    unpacked_t u;
    u.sign = w[WORD_W-1] ^ flip;
    u.exp  = w[WORD_W-2:MAN_W];
    u.man  = {1'b1, w[MAN_W-1:0]};
    if (u.exp == '0) u.man = '0;
    return u;
  endfunction
endpackage

// File: rtl/fpa_add_unit_if.sv
// Request/result bundle between control and the adder.
// start is a one-cycle pulse honoured only while busy is low; done pulses
// for one cycle when fpa_sum/fpa_ovf/fpa_inv take their new values.
interface fpa_add_unit_if;
  import fpa_pkg::*;
  logic              start;
  logic              sub;
  logic [WORD_W-1:0] fpa_a;
  logic [WORD_W-1:0] fpa_b;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] fpa_sum;
  logic              fpa_ovf;
  logic              fpa_inv;

  modport master (output start, sub, fpa_a, fpa_b,
                  input  busy, done, fpa_sum, fpa_ovf, fpa_inv);
  modport slave  (input  start, sub, fpa_a, fpa_b,
                  output busy, done, fpa_sum, fpa_ovf, fpa_inv);
endinterface

// File: rtl/fpa_add_unit_lzc.sv
// Combinational leading-zero counter over the extended mantissa.
module fpa_lzc
  import fpa_pkg::*;
(
  input  logic [MX_W-1:0] i_val,
  output logic [LZ_W-1:0] o_cnt
);
  logic w_found;

  always_comb begin
    o_cnt   = LZ_W'(MX_W);
    w_found = 1'b0;
    for (int i = MX_W - 1; i >= 0; i--) begin
      if (!w_found && i_val[i]) begin
        o_cnt   = LZ_W'(MX_W - 1 - i);
        w_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fpa_add_unit.sv
// Five-state IEEE-754 single adder/subtractor: IDLE, ALIGN, ADD, NORM, ROUND.
// Results and flags are held in registers that change only on the done edge.
module fpa_add_unit
  import fpa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  fpa_add_unit_if.slave     bus,
  output state_t            o_dbg_state
);
  state_t            r_state, w_next;
  unpacked_t         r_a, r_b, w_ua, w_ub, w_big, w_small;
  logic              r_spec, r_spec_inv, w_spec, w_spec_inv;
  logic [WORD_W-1:0] r_spec_res, w_spec_res;
  logic              r_sign, r_eff_sub, r_zero;
  logic signed [EXP_W+1:0] r_exp, w_exp_norm, w_exp_r;
  logic [MX_W-1:0]   r_mx, r_my, r_mn, w_my;
  logic [MX_W:0]     r_sum;
  logic [EXP_W-1:0]  w_diff;
  logic [2*MX_W-1:0] w_shf;
  logic [LZ_W-1:0]   w_lz;
  logic [MAN_W+1:0]  w_rnd;
  logic [MAN_W-1:0]  w_frac;
  logic              w_rup;
  logic [WORD_W-1:0] r_out, w_res;
  logic              r_ovf, r_inv, r_done, w_res_ovf, w_res_inv;
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf;

  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = r_done;
  assign bus.fpa_sum  = r_out;
  assign bus.fpa_ovf  = r_ovf;
  assign bus.fpa_inv  = r_inv;
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_ALIGN;
      ST_ALIGN: w_next = ST_ADD;
      ST_ADD:   w_next = ST_NORM;
      ST_NORM:  w_next = ST_ROUND;
      ST_ROUND: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Special operands are resolved at unpack and carried alongside the datapath.
  always_comb begin
    w_ua    = unpack(bus.fpa_a, 1'b0);
    w_ub    = unpack(bus.fpa_b, bus.sub);
    w_a_nan = (&w_ua.exp) && (|w_ua.man[MAN_W-1:0]);
    w_b_nan = (&w_ub.exp) && (|w_ub.man[MAN_W-1:0]);
    w_a_inf = (&w_ua.exp) && !(|w_ua.man[MAN_W-1:0]);
    w_b_inf = (&w_ub.exp) && !(|w_ub.man[MAN_W-1:0]);
    w_spec     = 1'b1;
    w_spec_inv = 1'b0;
    w_spec_res = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_ua.sign != w_ub.sign))) begin
      w_spec_res = CANON_NAN;
      w_spec_inv = 1'b1;
    end else if (w_a_inf) begin
      w_spec_res = {w_ua.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_spec_res = {w_ub.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if ((w_ua.exp == '0) && (w_ub.exp == '0)) begin
      w_spec_res = {w_ua.sign & w_ub.sign, {(WORD_W-1){1'b0}}};
    end else begin
      w_spec = 1'b0;
    end
  end

  // Alignment: the low half of w_shf collects everything shifted past sticky.
  always_comb begin
    if ({r_a.exp, r_a.man} >= {r_b.exp, r_b.man}) begin
      w_big = r_a; w_small = r_b;
    end else begin
      w_big = r_b; w_small = r_a;
    end
    w_diff = w_big.exp - w_small.exp;
    w_shf  = {w_small.man, 3'b000, {MX_W{1'b0}}} >> w_diff;
    if (w_diff >= EXP_W'(MX_W - 1))
      w_my = {{(MX_W-1){1'b0}}, |w_small.man};
    else
      w_my = {w_shf[2*MX_W-1:MX_W+1], w_shf[MX_W] | (|w_shf[MX_W-1:0])};
  end

  fpa_lzc u_lzc (
    .i_val (r_sum[MX_W-1:0]),
    .o_cnt (w_lz)
  );

  assign w_exp_norm = r_exp - $signed({{(EXP_W+2-LZ_W){1'b0}}, w_lz});

  // Round-to-nearest-even on guard/round/sticky, then final packing.
  always_comb begin
    w_rup     = r_mn[2] & (r_mn[1] | r_mn[0] | r_mn[3]);
    w_rnd     = {1'b0, r_mn[MX_W-1:3]} + {{(MAN_W+1){1'b0}}, w_rup};
    w_exp_r   = w_rnd[MAN_W+1] ? r_exp + 10'sd1 : r_exp;
    w_frac    = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    w_res_ovf = 1'b0;
    w_res_inv = 1'b0;
    if (r_spec) begin
      w_res     = r_spec_res;
      w_res_inv = r_spec_inv;
    end else if (r_zero) begin
      w_res = {r_sign, {(WORD_W-1){1'b0}}};
    end else if (w_exp_r >= (EXP_W+2)'(EXP_MAX)) begin
      w_res     = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_res_ovf = 1'b1;
    end else begin
      w_res = {r_sign, w_exp_r[EXP_W-1:0], w_frac};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a <= '0; r_b <= '0;
      r_spec <= 1'b0; r_spec_inv <= 1'b0; r_spec_res <= '0;
      r_sign <= 1'b0; r_eff_sub <= 1'b0; r_zero <= 1'b0;
      r_exp <= '0; r_mx <= '0; r_my <= '0; r_mn <= '0; r_sum <= '0;
      r_out <= '0; r_ovf <= 1'b0; r_inv <= 1'b0; r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_a        <= w_ua;
          r_b        <= w_ub;
          r_spec     <= w_spec;
          r_spec_inv <= w_spec_inv;
          r_spec_res <= w_spec_res;
        end
        ST_ALIGN: begin
          r_sign    <= w_big.sign;
          r_eff_sub <= w_big.sign ^ w_small.sign;
          r_exp     <= $signed({2'b00, w_big.exp});
          r_mx      <= {w_big.man, 3'b000};
          r_my      <= w_my;
        end
        ST_ADD: r_sum <= r_eff_sub ? ({1'b0, r_mx} - {1'b0, r_my})
                                   : ({1'b0, r_mx} + {1'b0, r_my});
        ST_NORM: begin
          if (r_sum[MX_W]) begin
            r_mn   <= {r_sum[MX_W:2], r_sum[1] | r_sum[0]};
            r_exp  <= r_exp + 10'sd1;
            r_zero <= 1'b0;
          end else if (r_sum == '0) begin
            r_sign <= 1'b0;
            r_zero <= 1'b1;
          end else begin
            r_mn   <= r_sum[MX_W-1:0] << w_lz;
            r_exp  <= w_exp_norm;
            r_zero <= (w_exp_norm <= 10'sd0);
          end
        end
        ST_ROUND: begin
          r_out  <= w_res;
          r_ovf  <= w_res_ovf;
          r_inv  <= w_res_inv;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpa_add_unit.sv
// Directed-vector bench for fpa_add_unit: hand-computed sums, fixed latency,
// busy window, ignored/back-to-back starts and reset abort.
module tb_fpa_add_unit;
  import fpa_pkg::*;

  localparam logic [31:0] ONE = {1'b0, EXP_W'(EXP_BIAS), MAN_W'(0)};

  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;

  fpa_add_unit_if bus();

  fpa_add_unit dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int n_exp_done = 0;
  logic [33:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse is compared with the oldest expected {ovf,inv,sum}.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() != 0)
        check(tag_q.pop_front(), {bus.fpa_ovf, bus.fpa_inv, bus.fpa_sum}, exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Called #1 after an edge; start is sampled on the next edge.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] esum, input logic eovf,
                        input logic einv);
    int lat;
    int busy_n;
    exp_q.push_back({eovf, einv, esum});
    tag_q.push_back(tag);
    n_exp_done++;
    bus.fpa_a = a; bus.fpa_b = b; bus.sub = s; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; busy_n = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 34'(lat), 34'd4);
    check({tag, "_busy_cycles"}, 34'(busy_n), 34'd4);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.fpa_a = '0; bus.fpa_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_outputs", {bus.busy, bus.done, bus.fpa_ovf, bus.fpa_inv, bus.fpa_sum[29:0]},
          34'd0);
    check("reset_sum_hi", 34'(bus.fpa_sum[31:30]), 34'd0);
    check("reset_state", 34'(dbg_state), 34'(ST_IDLE));
    idle(1);

    run_op("add_1_2",      ONE,          32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0);
    idle(1);
    run_op("cancel",       ONE,          ONE,           1'b1, 32'h0000_0000, 1'b0, 1'b0);
    idle(1);
    run_op("neg_zeros",    32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
    idle(1);
    run_op("pos_neg_zero", 32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    idle(1);
    run_op("tie_even",     ONE,          32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    idle(1);
    run_op("above_tie",    ONE,          32'h3380_0001, 1'b0, 32'h3F80_0001, 1'b0, 1'b0);
    idle(1);
    run_op("tie_odd_up",   32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 1'b0, 1'b0);
    idle(1);
    run_op("sub_3_1",      32'h4040_0000, ONE,          1'b1, 32'h4000_0000, 1'b0, 1'b0);
    idle(1);
    run_op("sub_1_2",      ONE,          32'h4000_0000, 1'b1, 32'hBF80_0000, 1'b0, 1'b0);
    idle(1);
    run_op("overflow",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
    idle(1);
    run_op("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 1'b0, CANON_NAN, 1'b0, 1'b1);
    idle(1);
    run_op("inf_sub_inf",  32'h7F80_0000, 32'h7F80_0000, 1'b1, CANON_NAN, 1'b0, 1'b1);
    idle(1);
    run_op("nan_in",       32'h7FC0_0001, ONE,          1'b0, CANON_NAN, 1'b0, 1'b1);
    idle(1);
    run_op("inf_plus_fin", ONE,          32'hFF80_0000, 1'b0, 32'hFF80_0000, 1'b0, 1'b0);
    idle(1);
    run_op("denorm_flush", 32'h0000_0001, ONE,          1'b0, ONE,          1'b0, 1'b0);

    // Accepted in the very cycle after done: no idle in between.
    run_op("back_to_back", 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000, 1'b0, 1'b0);
    idle(2);

    // A second start two cycles into an op must be dropped.
    exp_q.push_back({2'b00, 32'h4040_0000});
    tag_q.push_back("ignore_start");
    n_exp_done++;
    bus.fpa_a = ONE; bus.fpa_b = 32'h4000_0000; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idle(1);
    bus.fpa_a = 32'h40A0_0000; bus.fpa_b = 32'h40A0_0000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    t = 0;
    while (bus.done !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("ignore_start_timeout", 34'(t < 20), 34'd1);
    idle(10);
    check("ignore_start_done_count", 34'(done_cnt), 34'(n_exp_done));
    check("ignore_start_sum_held", 34'(bus.fpa_sum), 34'h0_4040_0000);

    // Reset while in NORM aborts without a done pulse.
    bus.fpa_a = 32'h4040_0000; bus.fpa_b = ONE; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idle(2);
    check("abort_in_norm_state", 34'(dbg_state), 34'(ST_NORM));
    reset = 1'b1;
    #1;
    check("abort_outputs", {bus.busy, bus.done, bus.fpa_ovf, bus.fpa_inv, bus.fpa_sum[29:0]},
          34'd0);
    check("abort_sum_hi", 34'(bus.fpa_sum[31:30]), 34'd0);
    check("abort_state", 34'(dbg_state), 34'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    idle(10);
    check("abort_no_done", 34'(done_cnt), 34'(n_exp_done));
    check("abort_sum_stays_zero", 34'(bus.fpa_sum), 34'd0);
    check("scoreboard_drained", 34'(exp_q.size()), 34'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
